// File: rtl/syncfifo.sv
// Single-clock FIFO with exact occupancy, live almost-full/almost-empty thresholds,
// overflow/underflow pulses and a choice of first-word-fall-through or registered read.
module syncfifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter string       RAM_STYLE  = "distributed",
    parameter bit          FWFT_EN    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   data_count,
    input  logic [ADDR_WIDTH:0]   prog_full_th,
    input  logic [ADDR_WIDTH:0]   prog_empty_th
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [DATA_WIDTH-1:0] head_c;
    logic                  wr_acc_c, rd_acc_c, mem_we_c;

    // Flags are plain compares on the registered occupancy.
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= prog_full_th);
    assign almost_empty = (count_q <= prog_empty_th);
    assign data_count   = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // Next-state: accepts judged on pre-edge flags; dout_q captures the word being popped.
    always_comb begin
        wr_acc_c = wr_en & ~full;
        rd_acc_c = rd_en & ~empty;
        mem_we_c = wr_acc_c & ~rst;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        dout_d   = dout_q;
        if (wr_acc_c) begin
            wptr_d = wptr_q + ADDR_WIDTH'(1);
        end
        if (rd_acc_c) begin
            rptr_d = rptr_q + ADDR_WIDTH'(1);
            dout_d = head_c;
        end
        count_d = count_q + CW'(wr_acc_c) - CW'(rd_acc_c);
        ovf_d   = wr_en & full;
        udf_d   = rd_en & empty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            dout_q  <= dout_d;
        end
    end

    // Storage is never reset; the attribute steers the mapping tool.
    if (RAM_STYLE == "block") begin : g_mem_block
        (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
        always_ff @(posedge clk) begin
            if (mem_we_c) begin
                mem[wptr_q] <= din;
            end
        end
        assign head_c = mem[rptr_q];
    end else begin : g_mem_dist
        (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
        always_ff @(posedge clk) begin
            if (mem_we_c) begin
                mem[wptr_q] <= din;
            end
        end
        assign head_c = mem[rptr_q];
    end

    // FWFT shows the live head, falling back to the last popped word when empty.
    if (FWFT_EN) begin : g_fwft
        assign dout = empty ? dout_q : head_c;
    end else begin : g_std
        assign dout = dout_q;
    end

endmodule
